// File: rtl/cam_dvp_tx.sv
// ---------------------------------------------------------------------------
// cam_dvp_tx
//   8-bit DVP (OV7670-style) camera stream source with a built-in RGB565 test
//   pattern generator. Drives the capture path in simulation and in on-board
//   loopback so capture and frame RAM can be exercised without a sensor.
//
// Ports
//   clk50MHz     in   system clock
//   reset        in   asynchronous, active-high reset
//   enable       in   run frames continuously while high (level)
//   mode[1:0]    in   0 colour bars, 1 byte counter, 2 solid, 3 checkerboard
//   color[15:0]  in   RGB565 value used by solid mode
//   pclk         out  pixel clock, 50% duty, PCLK_DIV system clocks per period
//   vsync        out  frame sync, active high
//   href         out  high while data carries valid pixel bytes
//   data[7:0]    out  pixel byte (RGB565, high byte first); 0 while href low
//   busy         out  high from frame start until frame end
//   frame_done   out  one-system-clock pulse at the end of every frame
//   frame_count  out  number of completed frames, wraps at 16 bits
// ---------------------------------------------------------------------------
module cam_dvp_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_DIV    = 2
) (
    input  logic        clk50MHz,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] color,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    localparam int              DIV_W     = $clog2(PCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PCLK_DIV / 2);
    localparam logic [15:0]     LINE_LEN  = 16'(2 * H_ACTIVE + H_BLANK);
    localparam logic [15:0]     HREF_LEN  = 16'(2 * H_ACTIVE);
    localparam int              BAR_W_INT = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [14:0]     BAR_W     = 15'(BAR_W_INT);

    // Number of lines spent in each vertical state.
    function automatic logic [15:0] state_lines(state_t s);
        case (s)
            VSYNC:   return 16'(VSYNC_LINES);
            VBACK:   return 16'(V_BACK);
            ACTIVE:  return 16'(V_ACTIVE);
            VFRONT:  return 16'(V_FRONT);
            default: return 16'd0;
        endcase
    endfunction

    // Next vertical state with a non-zero line count; IDLE marks end of frame.
    function automatic state_t state_after(state_t s);
        state_t r;
        r = IDLE;
        if (s == VSYNC && V_BACK > 0)
            r = VBACK;
        else if ((s == VSYNC || s == VBACK) && V_ACTIVE > 0)
            r = ACTIVE;
        else if ((s == VSYNC || s == VBACK || s == ACTIVE) && V_FRONT > 0)
            r = VFRONT;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // pclk divider. pclk is registered from the next divider value so it
    // falls on the same edge where the stream registers update (tick).
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_reg, div_next;
    logic             tick;
    logic             pclk_next;

    always_comb begin
        tick      = (div_reg == DIV_LAST);
        div_next  = tick ? '0 : div_reg + 1'b1;
        pclk_next = (div_next >= DIV_HALF);
    end

    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            div_reg <= '0;
            pclk    <= 1'b0;
        end else begin
            div_reg <= div_next;
            pclk    <= pclk_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame position FSM: state, column and per-state line counters.
    // ------------------------------------------------------------------
    state_t      state_reg, state_next, first_state;
    logic [15:0] col_reg, col_next;
    logic [15:0] line_reg, line_next;
    logic        frame_start, frame_end;

    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            line_reg  <= '0;
        end else if (tick) begin
            state_reg <= state_next;
            col_reg   <= col_next;
            line_reg  <= line_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        col_next    = col_reg;
        line_next   = line_reg;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        first_state = (VSYNC_LINES > 0) ? VSYNC : state_after(VSYNC);
        if (tick) begin
            if (state_reg == IDLE) begin
                if (enable) begin
                    frame_start = 1'b1;
                    state_next  = first_state;
                    col_next    = '0;
                    line_next   = '0;
                end
            end else if (col_reg != LINE_LEN - 16'd1) begin
                col_next = col_reg + 16'd1;
            end else begin
                col_next = '0;
                if (line_reg != state_lines(state_reg) - 16'd1) begin
                    line_next = line_reg + 16'd1;
                end else begin
                    line_next  = '0;
                    state_next = state_after(state_reg);
                    if (state_next == IDLE) begin
                        // Last slot of the frame: restart directly if still
                        // enabled so back-to-back frames have no gap.
                        frame_end = 1'b1;
                        if (enable) begin
                            frame_start = 1'b1;
                            state_next  = first_state;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pattern generation for the position being entered. Mode, colour and
    // the byte counter take their fresh frame-start values on the very tick
    // that starts a frame.
    // ------------------------------------------------------------------
    logic [1:0]  mode_reg, mode_eff;
    logic [15:0] color_reg, color_eff;
    logic [7:0]  byte_cnt_reg, byte_cnt_next, cnt_base;
    logic [14:0] px_x, bar_idx;
    logic [15:0] px_y;
    logic [2:0]  bar;
    logic [15:0] bar_color, pixel;
    logic        vsync_next, href_next, busy_next;
    logic [7:0]  data_next;

    always_comb begin
        mode_eff  = frame_start ? mode  : mode_reg;
        color_eff = frame_start ? color : color_reg;
        cnt_base  = frame_start ? 8'd0  : byte_cnt_reg;

        px_x    = col_next[15:1];
        px_y    = line_next;
        bar_idx = px_x / BAR_W;
        bar     = (bar_idx > 15'd7) ? 3'd7 : bar_idx[2:0];

        case (bar)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase

        case (mode_eff)
            2'd0:    pixel = bar_color;
            2'd2:    pixel = color_eff;
            2'd3:    pixel = (px_x[3] ^ px_y[3]) ? 16'h0000 : 16'hFFFF;
            default: pixel = 16'h0000;
        endcase

        vsync_next    = (state_next == VSYNC);
        href_next     = (state_next == ACTIVE) && (col_next < HREF_LEN);
        busy_next     = (state_next != IDLE);
        data_next     = 8'd0;
        byte_cnt_next = cnt_base;
        if (href_next) begin
            if (mode_eff == 2'd1)
                data_next = cnt_base;
            else
                data_next = col_next[0] ? pixel[7:0] : pixel[15:8];
            byte_cnt_next = cnt_base + 8'd1;
        end
    end

    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            vsync        <= 1'b0;
            href         <= 1'b0;
            data         <= 8'd0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= 16'd0;
            byte_cnt_reg <= 8'd0;
            mode_reg     <= 2'd0;
            color_reg    <= 16'd0;
        end else begin
            frame_done <= frame_end;
            if (tick) begin
                vsync        <= vsync_next;
                href         <= href_next;
                data         <= data_next;
                busy         <= busy_next;
                byte_cnt_reg <= byte_cnt_next;
                if (frame_start) begin
                    mode_reg  <= mode;
                    color_reg <= color;
                end
                if (frame_end)
                    frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cam_dvp_tx.sv
// ---------------------------------------------------------------------------
// tb_cam_dvp_tx
//   Self-checking bench for cam_dvp_tx with a small geometry. Each frame is
//   sampled at every pclk rising edge and compared with a reference computed
//   from the frame timing and pattern rules by plain arithmetic.
// ---------------------------------------------------------------------------
module tb_cam_dvp_tx;

    localparam int HA  = 4;
    localparam int HB  = 4;
    localparam int VA  = 3;
    localparam int VSL = 1;
    localparam int VB  = 1;
    localparam int VF  = 1;
    localparam int DIV = 2;

    localparam int L       = 2 * HA + HB;
    localparam int VS_T    = VSL * L;
    localparam int VB_T    = VB * L;
    localparam int ACT_T   = VA * L;
    localparam int VF_T    = VF * L;
    localparam int FRAME_T = VS_T + VB_T + ACT_T + VF_T;
    localparam int MID_T   = VS_T + VB_T + 6;
    localparam int BAR_W   = (HA / 8 > 0) ? HA / 8 : 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] color;
    logic        pclk, vsync, href, busy, frame_done;
    logic [7:0]  data;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int done_run = 0;
    int done_wide = 0;
    int exp_done = 0;
    logic [15:0] bar_colors [8];

    cam_dvp_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VSL),
        .V_BACK(VB), .V_FRONT(VF), .PCLK_DIV(DIV)
    ) dut (
        .clk50MHz(clk), .reset(rst), .enable(enable), .mode(mode), .color(color),
        .pclk(pclk), .vsync(vsync), .href(href), .data(data), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #10 clk = ~clk;

    // frame_done pulse counter and width monitor
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_run++;
            if (done_run == 1) done_pulses++;
            else               done_wide++;
        end else begin
            done_run = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observed();
        return {5'd0, busy, vsync, href, data, frame_count};
    endfunction

    // Reference: expected sample t pclk periods after the vsync rise.
    function automatic logic [31:0] expected_sample(input int t, input logic [1:0] m,
                                                    input logic [15:0] c, input logic [15:0] fc);
        logic        vs, hr;
        logic [7:0]  d;
        logic [15:0] px;
        int a, y, col, x, bar;
        vs = (t < VS_T);
        hr = 1'b0;
        d  = 8'd0;
        px = 16'd0;
        if (t >= VS_T + VB_T && t < VS_T + VB_T + ACT_T) begin
            a   = t - VS_T - VB_T;
            y   = a / L;
            col = a % L;
            if (col < 2 * HA) begin
                hr  = 1'b1;
                x   = col / 2;
                bar = x / BAR_W;
                if (bar > 7) bar = 7;
                case (m)
                    2'd0:    px = bar_colors[bar];
                    2'd2:    px = c;
                    2'd3:    px = (((x / 8) % 2) == ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
                    default: px = 16'h0000;
                endcase
                if (m == 2'd1) d = 8'((y * 2 * HA + col) % 256);
                else           d = (col % 2 == 0) ? px[15:8] : px[7:0];
            end
        end
        return {5'd0, 1'b1, vs, hr, d, fc};
    endfunction

    // Advance to the next negedge sample following a pclk rising edge.
    task automatic next_pclk_rise();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (pclk !== 1'b0 && n < 64);
        do begin @(negedge clk); n++; end while (pclk !== 1'b1 && n < 64);
        if (pclk !== 1'b1) check("pclk_rise_timeout", {31'd0, pclk}, 32'd1);
    endtask

    task automatic find_vsync();
        int n;
        n = 0;
        next_pclk_rise();
        while (vsync !== 1'b1 && n < 400) begin
            next_pclk_rise();
            n++;
        end
    endtask

    // Checks one whole frame; at MID_T applies the inputs for the next one.
    task automatic check_frame(input string name, input logic [1:0] m, input logic [15:0] c,
                               input logic [15:0] fc, input bit search,
                               input logic [1:0] nm, input logic [15:0] nc, input logic ne);
        int e0;
        e0 = errors;
        if (search) find_vsync();
        else        next_pclk_rise();
        check($sformatf("%s done_pulses", name), 32'(done_pulses), 32'(exp_done));
        for (int t = 0; t < FRAME_T; t++) begin
            if (t > 0) next_pclk_rise();
            check($sformatf("%s t=%0d", name, t), observed(), expected_sample(t, m, c, fc));
            if (t == MID_T) begin
                mode   = nm;
                color  = nc;
                enable = ne;
            end
        end
        exp_done++;
        $display("frame %s mode=%0d color=%h fc=%0d new_errors=%0d", name, m, c, fc, errors - e0);
    endtask

    initial begin
        logic [1:0]  fm   [10];
        logic [15:0] fcol [10];
        logic [1:0]  m;
        logic [15:0] c;

        bar_colors[0] = 16'hFFFF; bar_colors[1] = 16'hFFE0;
        bar_colors[2] = 16'h07FF; bar_colors[3] = 16'h07E0;
        bar_colors[4] = 16'hF81F; bar_colors[5] = 16'hF800;
        bar_colors[6] = 16'h001F; bar_colors[7] = 16'h0000;

        rst = 1'b1; enable = 1'b0; mode = 2'd0; color = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {3'd0, pclk, frame_done, busy, vsync, href, data, frame_count}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            check($sformatf("idle_pclk k=%0d", k), {31'd0, pclk}, ((k % DIV) >= DIV / 2) ? 32'd1 : 32'd0);
            check($sformatf("idle_out k=%0d", k), observed(), 32'd0);
        end
        $display("idle phase done checks=%0d", checks);

        fm[1] = 2'd1; fcol[1] = 16'($urandom);
        fm[2] = 2'd2; fcol[2] = 16'hABCD;
        fm[3] = 2'd0; fcol[3] = 16'($urandom);
        fm[4] = 2'd3; fcol[4] = 16'($urandom);
        for (int k = 5; k < 10; k++) begin
            fm[k]   = 2'($urandom_range(0, 3));
            fcol[k] = 16'($urandom);
        end

        mode = fm[1]; color = fcol[1]; enable = 1'b1;
        for (int k = 1; k <= 8; k++)
            check_frame($sformatf("f%0d", k), fm[k], fcol[k], 16'(k - 1), (k == 1),
                        fm[k + 1], fcol[k + 1], (k < 8));

        for (int i = 0; i < 20; i++) begin
            next_pclk_rise();
            check($sformatf("post_idle i=%0d", i), observed(), {16'd0, 16'd8});
        end
        check("post_idle done_pulses", 32'(done_pulses), 32'(exp_done));

        // Reset in the middle of the active region of a frame.
        m = 2'($urandom_range(0, 3)); c = 16'($urandom);
        mode = m; color = c; enable = 1'b1;
        find_vsync();
        for (int t = 1; t <= MID_T; t++) next_pclk_rise();
        check("pre_reset", observed(), expected_sample(MID_T, m, c, 16'd8));
        #3 rst = 1'b1;
        #1;
        check("async_reset", {3'd0, pclk, frame_done, busy, vsync, href, data, frame_count}, 32'd0);
        $display("mid-frame reset applied mode=%0d", m);
        repeat (3) @(negedge clk);
        c = 16'($urandom);
        mode = 2'd1; color = c;
        rst = 1'b0;
        check_frame("after_reset", 2'd1, c, 16'd0, 1'b1, 2'd2, c, 1'b0);
        for (int i = 0; i < 10; i++) begin
            next_pclk_rise();
            check($sformatf("final_idle i=%0d", i), observed(), {16'd0, 16'd1});
        end
        check("final done_pulses", 32'(done_pulses), 32'(exp_done));
        check("done_pulse_width", 32'(done_wide), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_dvp_tx.md
Name: cam_dvp_tx

Overview:
- Generates an 8-bit DVP (OV7670-style) camera stream: pclk, vsync, href and data, driven from an internal test-pattern generator.
- Is the transmit end of the interface consumed by the camera capture path. Feeds the capture block in simulation and on-board loopback, so capture and RAM can be verified without a sensor.
- Pixel format is RGB565, two bytes per pixel, high byte first.

Parameters:
- H_ACTIVE, 640, active pixels per line (each pixel is 2 pclk bytes).
- H_BLANK, 144, pclk cycles with href low after the active bytes of every line.
- V_ACTIVE, 480, active lines per frame.
- VSYNC_LINES, 3, lines with vsync high.
- V_BACK, 17, blank lines between vsync and the first active line.
- V_FRONT, 10, blank lines after the last active line.
- PCLK_DIV, 2, clk50MHz cycles per pclk period; must be even and ≥2.

Ports:
- clk50MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; run frames continuously while high
- mode  in  2  pattern: 0 colour bars, 1 byte counter, 2 solid, 3 checkerboard
- color  in  16  RGB565 value for solid mode
- pclk  out  1  pixel clock, 50% duty
- vsync  out  1  frame sync, active high
- href  out  1  high while data carries valid bytes
- data  out  8  pixel byte
- busy  out  1  high from frame start until frame end
- frame_done  out  1  one clk50MHz pulse at end of each frame
- frame_count  out  16  completed frames, wraps at 65535→0

Behaviour:
- Reset: all outputs 0, FSM to IDLE, all counters 0. Reset is asynchronous and may occur mid-frame: outputs return to 0 immediately, with no partial-frame completion.
- pclk generation:
  - Divider counter 0..PCLK_DIV-1; pclk is high for the second half of the period.
  - "tick" is the clk50MHz cycle in which pclk falls.
  - vsync, href and data update only on tick, so they are stable at every pclk rising edge.
- pclk runs continuously after reset, including in IDLE.
- Line length L = 2*H_ACTIVE + H_BLANK ticks. Column counter col runs 0..L-1; line counter runs per state.
- FSM (transitions on tick only):
  - IDLE: all outputs low except pclk. When enable=1, go to VSYNC; latch mode and color; set busy=1.
  - VSYNC: vsync=1 for VSYNC_LINES*L ticks, then go to VBACK.
  - VBACK: V_BACK*L ticks, then go to ACTIVE.
  - ACTIVE: V_ACTIVE lines. href=1 for col<2*H_ACTIVE, 0 otherwise. data=0 whenever href=0. After the last line, go to VFRONT.
  - VFRONT: V_FRONT*L ticks. At the end:
    - frame_done pulses and frame_count increments.
    - If enable=1, go to VSYNC, re-latching mode and color, with busy staying 1.
    - Otherwise go to IDLE with busy=0.
- enable falling mid-frame does not truncate the frame.
- Any count parameter equal to 0 skips its state.
- Pixel x = col>>1 and y = active line index. Byte phase col[0]: 0 = high byte, 1 = low byte.
- Mode 0, colour bars:
  - BAR_W = max(1, H_ACTIVE/8); bar = min(7, x/BAR_W).
  - Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Mode 1, byte counter: 8-bit counter, reset to 0 at frame start, incremented after each href byte, wraps 255→0.
- Mode 2: latched color.
- Mode 3, checkerboard: FFFF if x[3]^y[3]==0, else 0000.
- Changes to mode or color mid-frame have no effect until the next frame start.

Test Plan (params H_ACTIVE=4, H_BLANK=4, V_ACTIVE=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, PCLK_DIV=2; L=12, frame=72 pclk=144 clk):
- Reset, enable=0 for 50 cycles -> pclk toggles every clk; vsync=href=data=busy=0; frame_count=0.
- enable=1, mode=1 -> vsync high exactly 12 pclk. First href rises 24 pclk after vsync rise. Three href bursts of 8 bytes, 4 pclk gap each. Bytes 0x00..0x17 in order. frame_done one pulse; frame_count=1.
- mode=2, color=0xABCD -> each line sampled on pclk rise reads AB,CD,AB,CD,AB,CD,AB,CD.
- mode=0 -> line bytes FF,FF,FF,E0,07,FF,07,E0 (BAR_W=1, bars 0..3).
- enable held 1 for 3 frames, then dropped mid-frame 4 -> vsync periods of exactly 72 pclk. Frame 4 completes; frame_count=4; busy falls with the last frame_done; IDLE afterwards.
- Assert reset mid-ACTIVE -> href, vsync, data, busy go 0 asynchronously. After release with enable=1, a full frame restarts at VSYNC with counter pattern starting at 0x00.
